// File: rtl/difftest_pkg.sv
// ============================================================================
// Module  : difftest_pkg
// Brief   : Shared constants and commit-writeback record for difftest shadows.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package difftest_pkg;

  localparam int XLEN              = 64;
  localparam int NUM_ARCH_INT_REGS = 32;
  localparam int REG_IDX_W         = 5;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic [REG_IDX_W-1:0] wdest;
    logic [XLEN-1:0]      wdata;
  } commit_wb_t;

endpackage : difftest_pkg

`default_nettype wire

// File: rtl/difftest_snap_timer.sv
// ============================================================================
// Module  : difftest_snap_timer
// Brief   : Interval counter and dirty tracking; emits the registered snapshot strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module difftest_snap_timer #(
  parameter int SNAP_INTERVAL = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic any_commit,
  input  logic force_sync,
  output logic enable
);

  localparam int                c_cnt_w = (SNAP_INTERVAL > 1) ? $clog2(SNAP_INTERVAL) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SNAP_INTERVAL - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_dirty;
  logic               r_enable;
  logic               w_at_last;
  logic               w_issue;

  assign w_at_last = (r_cnt == c_last);
  assign w_issue   = force_sync | (w_at_last & (r_dirty | any_commit));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_dirty  <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      if (force_sync || w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      // A commit in the issuing cycle is already covered by that snapshot.
      r_dirty  <= w_issue ? 1'b0 : (r_dirty | any_commit);
      r_enable <= w_issue;
    end
  end

  assign enable = r_enable;

endmodule : difftest_snap_timer

`default_nettype wire

// File: rtl/difftest_arch_int_reg_shadow.sv
// ============================================================================
// Module  : difftest_arch_int_reg_shadow
// Brief   : Shadow integer register file fed by commit writebacks, with throttled snapshots.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module difftest_arch_int_reg_shadow
  import difftest_pkg::*;
#(
  parameter int         NCOMMIT       = 2,
  parameter int         SNAP_INTERVAL = 8,
  parameter logic [7:0] COREID        = 8'd0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NCOMMIT-1:0]            commit_valid,
  input  logic [NCOMMIT-1:0]            commit_wen,
  input  logic [REG_IDX_W*NCOMMIT-1:0]  commit_wdest,
  input  logic [XLEN*NCOMMIT-1:0]       commit_wdata,
  input  logic                          force_sync,
  output logic                          enable,
  output logic [XLEN-1:0]               io_value_0,
  output logic [XLEN-1:0]               io_value_1,
  output logic [XLEN-1:0]               io_value_2,
  output logic [XLEN-1:0]               io_value_3,
  output logic [XLEN-1:0]               io_value_4,
  output logic [XLEN-1:0]               io_value_5,
  output logic [XLEN-1:0]               io_value_6,
  output logic [XLEN-1:0]               io_value_7,
  output logic [XLEN-1:0]               io_value_8,
  output logic [XLEN-1:0]               io_value_9,
  output logic [XLEN-1:0]               io_value_10,
  output logic [XLEN-1:0]               io_value_11,
  output logic [XLEN-1:0]               io_value_12,
  output logic [XLEN-1:0]               io_value_13,
  output logic [XLEN-1:0]               io_value_14,
  output logic [XLEN-1:0]               io_value_15,
  output logic [XLEN-1:0]               io_value_16,
  output logic [XLEN-1:0]               io_value_17,
  output logic [XLEN-1:0]               io_value_18,
  output logic [XLEN-1:0]               io_value_19,
  output logic [XLEN-1:0]               io_value_20,
  output logic [XLEN-1:0]               io_value_21,
  output logic [XLEN-1:0]               io_value_22,
  output logic [XLEN-1:0]               io_value_23,
  output logic [XLEN-1:0]               io_value_24,
  output logic [XLEN-1:0]               io_value_25,
  output logic [XLEN-1:0]               io_value_26,
  output logic [XLEN-1:0]               io_value_27,
  output logic [XLEN-1:0]               io_value_28,
  output logic [XLEN-1:0]               io_value_29,
  output logic [XLEN-1:0]               io_value_30,
  output logic [XLEN-1:0]               io_value_31,
  output logic [7:0]                    io_coreid
);

  commit_wb_t      w_commit [NCOMMIT];
  logic [XLEN-1:0] w_regs   [NUM_ARCH_INT_REGS];

  for (genvar p = 0; p < NCOMMIT; p++) begin : g_port
    assign w_commit[p] = '{valid: commit_valid[p],
                           wen:   commit_wen[p],
                           wdest: commit_wdest[p*REG_IDX_W +: REG_IDX_W],
                           wdata: commit_wdata[p*XLEN +: XLEN]};
  end

  assign w_regs[0] = '0;

  // x0 has no storage, so writes aimed at it fall through without effect.
  for (genvar r = 1; r < NUM_ARCH_INT_REGS; r++) begin : g_reg
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] w_next;

    // Later ports are younger in program order, so the last match wins.
    always_comb begin
      w_next = r_q;
      for (int p = 0; p < NCOMMIT; p++) begin
        if (w_commit[p].valid && w_commit[p].wen &&
            (w_commit[p].wdest == REG_IDX_W'(r))) begin
          w_next = w_commit[p].wdata;
        end
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
      end else begin
        r_q <= w_next;
      end
    end

    assign w_regs[r] = r_q;
  end

  difftest_snap_timer #(
    .SNAP_INTERVAL (SNAP_INTERVAL)
  ) u_snap_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .any_commit (|commit_valid),
    .force_sync (force_sync),
    .enable     (enable)
  );

  assign io_coreid   = COREID;
  assign io_value_0  = w_regs[0];
  assign io_value_1  = w_regs[1];
  assign io_value_2  = w_regs[2];
  assign io_value_3  = w_regs[3];
  assign io_value_4  = w_regs[4];
  assign io_value_5  = w_regs[5];
  assign io_value_6  = w_regs[6];
  assign io_value_7  = w_regs[7];
  assign io_value_8  = w_regs[8];
  assign io_value_9  = w_regs[9];
  assign io_value_10 = w_regs[10];
  assign io_value_11 = w_regs[11];
  assign io_value_12 = w_regs[12];
  assign io_value_13 = w_regs[13];
  assign io_value_14 = w_regs[14];
  assign io_value_15 = w_regs[15];
  assign io_value_16 = w_regs[16];
  assign io_value_17 = w_regs[17];
  assign io_value_18 = w_regs[18];
  assign io_value_19 = w_regs[19];
  assign io_value_20 = w_regs[20];
  assign io_value_21 = w_regs[21];
  assign io_value_22 = w_regs[22];
  assign io_value_23 = w_regs[23];
  assign io_value_24 = w_regs[24];
  assign io_value_25 = w_regs[25];
  assign io_value_26 = w_regs[26];
  assign io_value_27 = w_regs[27];
  assign io_value_28 = w_regs[28];
  assign io_value_29 = w_regs[29];
  assign io_value_30 = w_regs[30];
  assign io_value_31 = w_regs[31];

endmodule : difftest_arch_int_reg_shadow

`default_nettype wire

// File: tb/tb_difftest_arch_int_reg_shadow.sv
// ============================================================================
// Module  : tb_difftest_arch_int_reg_shadow
// Brief   : Directed self-checking bench for the integer register shadow (interval 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_difftest_arch_int_reg_shadow;

  localparam int         NC = 2;
  localparam int         SI = 4;
  localparam logic [7:0] CID = 8'h3C;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NC-1:0]   commit_valid;
  logic [NC-1:0]   commit_wen;
  logic [5*NC-1:0] commit_wdest;
  logic [64*NC-1:0] commit_wdata;
  logic            force_sync;
  logic            enable;
  logic [63:0]     vals [32];
  logic [7:0]      io_coreid;

  int n_asserts = 0;
  int n_fail    = 0;
  int mcnt      = 0;
  int en_count  = 0;

  always #5 clock = ~clock;

  difftest_arch_int_reg_shadow #(
    .NCOMMIT       (NC),
    .SNAP_INTERVAL (SI),
    .COREID        (CID)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .commit_valid (commit_valid),
    .commit_wen   (commit_wen),
    .commit_wdest (commit_wdest),
    .commit_wdata (commit_wdata),
    .force_sync   (force_sync),
    .enable       (enable),
    .io_value_0   (vals[0]),  .io_value_1  (vals[1]),  .io_value_2  (vals[2]),  .io_value_3  (vals[3]),
    .io_value_4   (vals[4]),  .io_value_5  (vals[5]),  .io_value_6  (vals[6]),  .io_value_7  (vals[7]),
    .io_value_8   (vals[8]),  .io_value_9  (vals[9]),  .io_value_10 (vals[10]), .io_value_11 (vals[11]),
    .io_value_12  (vals[12]), .io_value_13 (vals[13]), .io_value_14 (vals[14]), .io_value_15 (vals[15]),
    .io_value_16  (vals[16]), .io_value_17 (vals[17]), .io_value_18 (vals[18]), .io_value_19 (vals[19]),
    .io_value_20  (vals[20]), .io_value_21 (vals[21]), .io_value_22 (vals[22]), .io_value_23 (vals[23]),
    .io_value_24  (vals[24]), .io_value_25 (vals[25]), .io_value_26 (vals[26]), .io_value_27 (vals[27]),
    .io_value_28  (vals[28]), .io_value_29 (vals[29]), .io_value_30 (vals[30]), .io_value_31 (vals[31]),
    .io_coreid    (io_coreid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; mcnt tracks the phase of the interval counter for alignment only.
  task automatic tick();
    @(posedge clock);
    mcnt = force_sync ? 0 : ((mcnt == SI - 1) ? 0 : mcnt + 1);
    #1;
    en_count += int'(enable);
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 2 * SI && mcnt != v; i++) tick();
  endtask

  task automatic drive(input int p, input bit v, input bit w, input int d, input logic [63:0] data);
    commit_valid[p]          = v;
    commit_wen[p]            = w;
    commit_wdest[p*5 +: 5]   = d[4:0];
    commit_wdata[p*64 +: 64] = data;
  endtask

  task automatic clear();
    commit_valid = '0;
    commit_wen   = '0;
    commit_wdest = '0;
    commit_wdata = '0;
    force_sync   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    clear();
    #3;
    chk("reset_enable", 64'(enable), 64'd0);
    for (int k = 0; k < 32; k++) chk($sformatf("reset_x%0d", k), vals[k], 64'd0);
    chk("coreid", 64'(io_coreid), 64'h3C);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    mcnt = 0;

    // Idle: no commits, no snapshots.
    en_count = 0;
    repeat (50) tick();
    chk("idle_enable_count", 64'(en_count), 64'd0);
    for (int k = 0; k < 32; k++) chk($sformatf("idle_x%0d", k), vals[k], 64'd0);

    // Single write, snapshot at the boundary, then quiet.
    wait_cnt(1);
    drive(0, 1, 1, 5, 64'h1234);
    tick(); clear();
    chk("x5_written", vals[5], 64'h1234);
    chk("en_cnt2", 64'(enable), 64'd0);
    tick();
    chk("en_cnt3", 64'(enable), 64'd0);
    tick();
    chk("snap_pulse", 64'(enable), 64'd1);
    en_count = 0;
    repeat (8) tick();
    chk("quiet_after_snap", 64'(en_count), 64'd0);

    // Same-index priority, parallel distinct writes, x0 drop, wen without valid.
    wait_cnt(1);
    drive(0, 1, 1, 7, 64'hAAAA);
    drive(1, 1, 1, 7, 64'hBBBB);
    tick(); clear();
    chk("x7_port1_wins", vals[7], 64'hBBBB);
    drive(0, 1, 1, 9, 64'h99);
    drive(1, 1, 1, 10, 64'h1010);
    tick(); clear();
    chk("x9_parallel", vals[9], 64'h99);
    chk("x10_parallel", vals[10], 64'h1010);
    chk("en_before_boundary", 64'(enable), 64'd0);
    tick();
    chk("snap_after_writes", 64'(enable), 64'd1);
    wait_cnt(1);
    drive(0, 1, 1, 0, 64'hFFFF);
    drive(1, 0, 1, 8, 64'hDEAD);
    tick(); clear();
    chk("x0_stays_zero", vals[0], 64'd0);
    chk("x8_wen_no_valid", vals[8], 64'd0);

    // Valid without wen: no register change but still dirty.
    wait_cnt(1);
    drive(0, 1, 0, 5, 64'h9999);
    tick(); clear();
    chk("x5_unchanged", vals[5], 64'h1234);
    chk("nowen_en_cnt2", 64'(enable), 64'd0);
    tick();
    chk("nowen_en_cnt3", 64'(enable), 64'd0);
    tick();
    chk("nowen_snap", 64'(enable), 64'd1);
    tick();
    chk("nowen_pulse_end", 64'(enable), 64'd0);

    // Force with nothing dirty.
    wait_cnt(1);
    force_sync = 1'b1;
    tick(); clear();
    chk("force_enable", 64'(enable), 64'd1);
    en_count = 0;
    repeat (8) tick();
    chk("force_then_idle", 64'(en_count), 64'd0);

    // Force realigns the interval: next boundary is four cycles after it.
    wait_cnt(2);
    force_sync = 1'b1;
    tick(); clear();
    chk("force2_enable", 64'(enable), 64'd1);
    drive(0, 1, 1, 12, 64'h77);
    tick(); clear();
    chk("realign_en1", 64'(enable), 64'd0);
    chk("x12_written", vals[12], 64'h77);
    tick();
    chk("realign_en2", 64'(enable), 64'd0);
    tick();
    chk("realign_en3", 64'(enable), 64'd0);
    tick();
    chk("realign_snap", 64'(enable), 64'd1);

    // Commit in the issuing cycle leaves nothing dirty.
    wait_cnt(3);
    drive(1, 1, 1, 13, 64'h1313);
    tick(); clear();
    chk("boundary_commit_snap", 64'(enable), 64'd1);
    chk("x13_written", vals[13], 64'h1313);
    en_count = 0;
    repeat (8) tick();
    chk("dirty_cleared", 64'(en_count), 64'd0);

    // Held force issues every cycle.
    force_sync = 1'b1;
    tick();
    chk("held_force_1", 64'(enable), 64'd1);
    tick();
    chk("held_force_2", 64'(enable), 64'd1);
    tick();
    chk("held_force_3", 64'(enable), 64'd1);
    clear();
    tick();
    chk("held_force_release", 64'(enable), 64'd0);

    // Asynchronous reset mid-stream drops pending snapshot and shadow state.
    wait_cnt(1);
    drive(0, 1, 1, 3, 64'h55);
    tick(); clear();
    chk("x3_written", vals[3], 64'h55);
    reset_n = 1'b0;
    #1;
    chk("async_reset_x3", vals[3], 64'd0);
    chk("async_reset_x7", vals[7], 64'd0);
    chk("async_reset_en", 64'(enable), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    mcnt = 0;
    en_count = 0;
    repeat (12) tick();
    chk("no_snap_after_reset", 64'(en_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_difftest_arch_int_reg_shadow

`default_nettype wire

// File: doc/difftest_arch_int_reg_shadow.md
# difftest_arch_int_reg_shadow

Maintains a shadow copy of the 32 architectural integer registers from committed-instruction writeback events and periodically presents a consistent snapshot to the difftest integer-register-state checker. It sits between the core's commit stage and the DPI-C register-state reporter, and drives that reporter's `enable`, `io_value_0..31` and `io_coreid` inputs directly. Snapshot rate is throttled by a programmable interval to bound simulation DPI overhead.

## Interface
- `NCOMMIT`, 2: commit ports per cycle (1..6); port index order = program order.
- `SNAP_INTERVAL`, 8: cycles between snapshot opportunities (1..256); 1 = every cycle.
- `COREID`, 0: 8-bit core id driven on `io_coreid`.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `commit_valid`  in  NCOMMIT  per-port instruction committed this cycle.
- `commit_wen`  in  NCOMMIT  per-port integer register write.
- `commit_wdest`  in  5*NCOMMIT  per-port destination index.
- `commit_wdata`  in  64*NCOMMIT  per-port write data.
- `force_sync`  in  1  request an immediate snapshot (trap, CSR write, end of test).
- `enable`  out  1  one-cycle snapshot strobe to the checker.
- `io_value_0` … `io_value_31`  out  64 each  shadow register values.
- `io_coreid`  out  8  constant `COREID`.

## Operation
- Shadow file: 31 × 64-bit registers (x1..x31); `io_value_0` is tied to 0.
- Write qualification: port i writes when `commit_valid[i] & commit_wen[i] & (commit_wdest[i] != 0)`. Writes to x0 are dropped and do not fault.
- Same-cycle writes to the same index: the highest-numbered qualified port wins. `wen` without `valid` is ignored.
- `dirty` flag: set by any `commit_valid` bit, including instructions that do not write. It is cleared in the cycle a snapshot is issued. If a commit and an issue occur in the same cycle, `dirty` ends cleared, because that commit is covered by the snapshot.
- Interval counter `cnt`:
  - Width `$clog2(SNAP_INTERVAL)`, minimum 1 bit.
  - Counts 0..SNAP_INTERVAL-1 and wraps to 0.
  - Free-running, independent of commits.
- Issue condition in cycle t: `force_sync | ((cnt == SNAP_INTERVAL-1) & (dirty | |commit_valid))`.
- On issue, `enable` is 1 in cycle t+1 and 0 in all other cycles. No back-pressure: the checker always accepts.
- `force_sync` resets `cnt` to 0 in the same edge, overriding the wrap. It issues even when there is no dirty state. A held `force_sync` issues every cycle.
- `io_coreid` is combinational from the parameter.

## Timing
- Reset, asynchronous assert: all shadow registers 0, `enable` 0, `cnt` 0, `dirty` 0. Outputs change immediately.
- Reset release is synchronous to `clock`. The first edge after release may capture commits.
- Commit at edge t is visible on `io_value_*` from t+1; there is no combinational path from commit inputs to outputs.
- Snapshot consistency: when `enable` = 1 in cycle t+1, `io_value_*` reflect all commits up to and including cycle t.
- Reset asserted mid-stream: any pending snapshot is dropped and `dirty` is lost.
- `SNAP_INTERVAL` = 1: `enable` follows `|commit_valid | force_sync` delayed by one cycle.

## Structure
- Shared package `difftest_pkg`:
  - Constants `XLEN` = 64, `NUM_ARCH_INT_REGS` = 32, `REG_IDX_W` = 5.
  - Typedef `commit_wb_t` with fields `valid`, `wen`, `wdest`, `wdata`, for later reuse by the FP shadow block.
- One natural sub-module, `difftest_snap_timer`: holds `cnt`, `dirty` and `force_sync` and emits the registered `enable`.
- The shadow file and the priority write merge stay in the top module.

## Test plan
- Reset, then no commits for 50 cycles -> `enable` never asserts; all `io_value_*` = 0.
- `SNAP_INTERVAL`=4; port 0 writes x5=0x1234 at cycle 1 -> `io_value_5`=0x1234 from cycle 2; a single `enable` pulse in the cycle after `cnt`==3, then none while idle.
- Same cycle, port 0 writes x7=0xAAAA and port 1 writes x7=0xBBBB -> `io_value_7`=0xBBBB. A write to x0=0xFFFF -> `io_value_0` stays 0.
- `valid`=1 with `wen`=0 -> no register change, but `dirty` is set and `enable` pulses at the next interval boundary.
- `force_sync` at `cnt`=1 with `dirty`=0 -> `enable` next cycle; `cnt`=0 the following cycle; the next interval-based issue comes 4 cycles later, only if dirty.
- Assert `reset_n`=0 while `dirty`=1 and x3=0x55 -> `io_value_3`=0 immediately, and no `enable` after release without new commits.
